// File: rtl/xalu_ise_pkg.sv
// xalu_ise_pkg -- definitions shared by the ISE sequencer, its bus
// interface and the ISE ALU that sits beside it.
//   state_t      : sequencer FSM encoding
//   CUSTOM_0..3  : fn codes of the custom-instruction slots
//   TAG_W        : destination register index width
package xalu_ise_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // fn codes of the custom-op slots. The ALU build decides which ones it
  // actually implements; the sequencer only passes fn through.
  localparam logic [5:0] CUSTOM_0 = 6'd0;
  localparam logic [5:0] CUSTOM_1 = 6'd1;
  localparam logic [5:0] CUSTOM_2 = 6'd2;
  localparam logic [5:0] CUSTOM_3 = 6'd3;

  localparam int TAG_W = 5;

endpackage

// File: rtl/xalu_ise_seq_if.sv
// xalu_ise_seq_if -- core-side request/response bus of the ISE sequencer.
//   req_* : request handshake + opcode fields/operands/destination tag
//   rsp_* : response handshake + result, echoed tag, illegal-op flag
// Modports: master = core, slave = sequencer.
interface xalu_ise_seq_if;
  import xalu_ise_pkg::*;

  logic             req_val;
  logic             req_rdy;
  logic [5:0]       req_fn;
  logic [6:0]       req_imm;
  logic [31:0]      req_rs1;
  logic [31:0]      req_rs2;
  logic [TAG_W-1:0] req_tag;

  logic             rsp_val;
  logic             rsp_rdy;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_illegal;

  modport master (
    output req_val, req_fn, req_imm, req_rs1, req_rs2, req_tag, rsp_rdy,
    input  req_rdy, rsp_val, rsp_data, rsp_tag, rsp_illegal
  );

  modport slave (
    input  req_val, req_fn, req_imm, req_rs1, req_rs2, req_tag, rsp_rdy,
    output req_rdy, rsp_val, rsp_data, rsp_tag, rsp_illegal
  );

endinterface

// File: rtl/xalu_ise_seq.sv
// xalu_ise_seq -- sequences one core request through the ISE ALU.
// Takes a request in IDLE, presents the captured operands to the ALU in
// EXEC until it accepts (ise_oval) or WAIT_MAX cycles pass (op flagged
// illegal), then holds the response in RESP until the core takes it.
// Ports:
//   ise_clk, ise_rst : clock, synchronous active-high reset
//   bus (slave)      : core request/response handshake
//   ise_fn/imm/in1/in2/val : drive the ISE ALU (connected one-to-one by
//                      the parent, which instantiates xalu_ise beside us)
//   ise_oval, ise_out: ALU accept flag and result (only looked at in EXEC)
// Config macro: XALU_ISE_SEQ_B2B_EN -- accept the next request in the same
//   cycle the response is taken, going straight RESP->EXEC.
module xalu_ise_seq
  import xalu_ise_pkg::*;
#(
  parameter int WAIT_MAX = 4   // 1..15
) (
  input  logic          ise_clk,
  input  logic          ise_rst,
  xalu_ise_seq_if.slave bus,
  output logic [5:0]    ise_fn,
  output logic [6:0]    ise_imm,
  output logic [31:0]   ise_in1,
  output logic [31:0]   ise_in2,
  output logic          ise_val,
  input  logic          ise_oval,
  input  logic [31:0]   ise_out
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_MAX - 1);

  state_t           r_state;
  logic [5:0]       r_fn;
  logic [6:0]       r_imm;
  logic [31:0]      r_rs1;
  logic [31:0]      r_rs2;
  logic [TAG_W-1:0] r_tag;
  logic [3:0]       r_cnt;
  logic             r_ise_val;
  logic             r_rsp_val;
  logic [31:0]      r_rsp_data;
  logic [TAG_W-1:0] r_rsp_tag;
  logic             r_rsp_illegal;
  logic             w_req_rdy;
  logic             w_cap;

  // req_rdy depends on rsp_rdy in RESP when back-to-back is enabled, so it
  // is decoded from state rather than registered.
`ifdef XALU_ISE_SEQ_B2B_EN
  assign w_req_rdy = (r_state == IDLE) | ((r_state == RESP) & bus.rsp_rdy);
`else
  assign w_req_rdy = (r_state == IDLE);
`endif
  assign w_cap = bus.req_val & w_req_rdy;

  always_ff @(posedge ise_clk) begin
    if (ise_rst) begin
      r_state       <= IDLE;
      r_fn          <= '0;
      r_imm         <= '0;
      r_rs1         <= '0;
      r_rs2         <= '0;
      r_tag         <= '0;
      r_cnt         <= '0;
      r_ise_val     <= 1'b0;
      r_rsp_val     <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_tag     <= '0;
      r_rsp_illegal <= 1'b0;
    end else begin
      // Capture registers change only on a request transfer, so the ALU
      // operands stay stable from EXEC entry until the next capture.
      if (w_cap) begin
        r_fn  <= bus.req_fn;
        r_imm <= bus.req_imm;
        r_rs1 <= bus.req_rs1;
        r_rs2 <= bus.req_rs2;
        r_tag <= bus.req_tag;
        r_cnt <= '0;
      end
      case (r_state)
        IDLE: begin
          if (w_cap) begin
            r_state   <= EXEC;
            r_ise_val <= 1'b1;
          end
        end
        EXEC: begin
          // Accept on the last allowed cycle wins over the timeout.
          if (ise_oval) begin
            r_state       <= RESP;
            r_ise_val     <= 1'b0;
            r_rsp_val     <= 1'b1;
            r_rsp_data    <= ise_out;
            r_rsp_tag     <= r_tag;
            r_rsp_illegal <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == WAIT_LAST) begin
              r_state       <= RESP;
              r_ise_val     <= 1'b0;
              r_rsp_val     <= 1'b1;
              r_rsp_data    <= '0;
              r_rsp_tag     <= r_tag;
              r_rsp_illegal <= 1'b1;
            end
          end
        end
        RESP: begin
          if (bus.rsp_rdy) begin
            r_rsp_val <= 1'b0;
            if (w_cap) begin
              r_state   <= EXEC;
              r_ise_val <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          r_ise_val <= 1'b0;
          r_rsp_val <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_rdy     = w_req_rdy;
  assign bus.rsp_val     = r_rsp_val;
  assign bus.rsp_data    = r_rsp_data;
  assign bus.rsp_tag     = r_rsp_tag;
  assign bus.rsp_illegal = r_rsp_illegal;

  assign ise_fn  = r_fn;
  assign ise_imm = r_imm;
  assign ise_in1 = r_rs1;
  assign ise_in2 = r_rs2;
  assign ise_val = r_ise_val;

endmodule

// File: tb/tb_xalu_ise_seq.sv
// tb_xalu_ise_seq -- directed test of xalu_ise_seq with WAIT_MAX=4.
// The bench plays both the core and the ISE ALU; inputs change and outputs
// are sampled 1ns after each rising edge.
module tb_xalu_ise_seq;
  import xalu_ise_pkg::*;

  localparam int WAIT_MAX = 4;
`ifdef XALU_ISE_SEQ_B2B_EN
  localparam int OP_PERIOD = 2;
`else
  localparam int OP_PERIOD = 3;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  ise_fn;
  logic [6:0]  ise_imm;
  logic [31:0] ise_in1, ise_in2;
  logic        ise_val;
  logic        ise_oval;
  logic [31:0] ise_out;

  int n_chk  = 0;
  int n_fail = 0;

  xalu_ise_seq_if bus ();

  xalu_ise_seq #(.WAIT_MAX(WAIT_MAX)) dut (
    .ise_clk (clk),
    .ise_rst (rst),
    .bus     (bus.slave),
    .ise_fn  (ise_fn),
    .ise_imm (ise_imm),
    .ise_in1 (ise_in1),
    .ise_in2 (ise_in2),
    .ise_val (ise_val),
    .ise_oval(ise_oval),
    .ise_out (ise_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h @%0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [5:0] fn, input logic [6:0] imm,
                           input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [4:0] tag);
    bus.req_val = 1'b1;
    bus.req_fn  = fn;
    bus.req_imm = imm;
    bus.req_rs1 = rs1;
    bus.req_rs2 = rs2;
    bus.req_tag = tag;
  endtask

  initial begin
    int hi_cnt;
    bit done;
    logic [31:0] d0;

    rst = 1'b1;
    bus.req_val = 1'b0; bus.req_fn = '0; bus.req_imm = '0;
    bus.req_rs1 = '0; bus.req_rs2 = '0; bus.req_tag = '0;
    bus.rsp_rdy = 1'b0;
    ise_oval = 1'b0; ise_out = '0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    chk("rst_req_rdy", 32'(bus.req_rdy), 32'd1);
    chk("rst_rsp_val", 32'(bus.rsp_val), 32'd0);
    chk("rst_ise_val", 32'(ise_val), 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_rsp_tag", 32'(bus.rsp_tag), 32'd0);
    chk("rst_ise_in1", ise_in1, 32'd0);

    // single-cycle op; oval high in IDLE must be ignored
    drive_req(CUSTOM_1, 7'd0, 32'h1234_5678, 32'h0, 5'd7);
    ise_oval = 1'b1; ise_out = 32'hCAFE_F00D;
    tick();
    chk("idle_oval_ignored", 32'(bus.rsp_val), 32'd0);
    bus.req_val = 1'b0;
    chk("exec_ise_val", 32'(ise_val), 32'd1);
    chk("exec_ise_fn", 32'(ise_fn), 32'd1);
    chk("exec_ise_in1", ise_in1, 32'h1234_5678);
    chk("exec_req_rdy", 32'(bus.req_rdy), 32'd0);
    tick();
    ise_oval = 1'b0; ise_out = 32'hDEAD_BEEF;
    chk("op1_rsp_val", 32'(bus.rsp_val), 32'd1);
    chk("op1_rsp_data", bus.rsp_data, 32'hCAFE_F00D);
    chk("op1_rsp_tag", 32'(bus.rsp_tag), 32'd7);
    chk("op1_illegal", 32'(bus.rsp_illegal), 32'd0);
    chk("op1_ise_val", 32'(ise_val), 32'd0);

    // response back-pressure for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_rsp_val", 32'(bus.rsp_val), 32'd1);
      chk("hold_rsp_data", bus.rsp_data, 32'hCAFE_F00D);
      chk("hold_rsp_tag", 32'(bus.rsp_tag), 32'd7);
      chk("hold_req_rdy", 32'(bus.req_rdy), 32'd0);
    end
    bus.rsp_rdy = 1'b1;
    tick();
    bus.rsp_rdy = 1'b0;
    chk("op1_done_rsp_val", 32'(bus.rsp_val), 32'd0);
    chk("op1_done_req_rdy", 32'(bus.req_rdy), 32'd1);

    // unsupported op: ALU never accepts -> illegal after WAIT_MAX EXEC cycles
    drive_req(6'b000011, 7'd5, 32'h1, 32'h2, 5'd3);
    tick();
    bus.req_val = 1'b0;
    hi_cnt = 0;
    done = 1'b0;
    for (int i = 0; i < 12 && !done; i++) begin
      if (bus.rsp_val) done = 1'b1;
      else begin
        if (ise_val) hi_cnt++;
        tick();
      end
    end
    chk("ill_seen", 32'(done), 32'd1);
    chk("ill_ise_val_cycles", 32'(hi_cnt), 32'(WAIT_MAX));
    chk("ill_illegal", 32'(bus.rsp_illegal), 32'd1);
    chk("ill_data", bus.rsp_data, 32'd0);
    chk("ill_tag", 32'(bus.rsp_tag), 32'd3);
    bus.rsp_rdy = 1'b1;
    tick();
    bus.rsp_rdy = 1'b0;

    // accept on the last allowed EXEC cycle beats the timeout
    drive_req(CUSTOM_2, 7'd0, 32'h5, 32'h6, 5'd4);
    tick();
    bus.req_val = 1'b0;
    for (int i = 1; i < WAIT_MAX; i++) begin
      chk("late_ise_val", 32'(ise_val), 32'd1);
      tick();
    end
    chk("late_last_ise_val", 32'(ise_val), 32'd1);
    ise_oval = 1'b1; ise_out = 32'h1;
    tick();
    ise_oval = 1'b0; ise_out = 32'h0;
    chk("late_rsp_val", 32'(bus.rsp_val), 32'd1);
    chk("late_illegal", 32'(bus.rsp_illegal), 32'd0);
    chk("late_data", bus.rsp_data, 32'h1);
    bus.rsp_rdy = 1'b1;
    tick();
    bus.rsp_rdy = 1'b0;

    // reset during EXEC aborts the op
    drive_req(CUSTOM_0, 7'd9, 32'hAAAA_5555, 32'h1, 5'd12);
    tick();
    bus.req_val = 1'b0;
    chk("abort_in_exec", 32'(ise_val), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_req_rdy", 32'(bus.req_rdy), 32'd1);
    chk("abort_ise_val", 32'(ise_val), 32'd0);
    chk("abort_ise_in1", ise_in1, 32'd0);
    chk("abort_rsp_data", bus.rsp_data, 32'd0);
    chk("abort_rsp_tag", 32'(bus.rsp_tag), 32'd0);
    ise_oval = 1'b1; ise_out = 32'h7777_7777;
    tick(); tick();
    chk("abort_no_rsp", 32'(bus.rsp_val), 32'd0);
    ise_oval = 1'b0;
    drive_req(CUSTOM_1, 7'd0, 32'h9, 32'h9, 5'd9);
    tick();
    bus.req_val = 1'b0;
    ise_oval = 1'b1; ise_out = 32'h0000_BEEF;
    tick();
    ise_oval = 1'b0;
    chk("post_rst_rsp_val", 32'(bus.rsp_val), 32'd1);
    chk("post_rst_data", bus.rsp_data, 32'h0000_BEEF);
    chk("post_rst_tag", 32'(bus.rsp_tag), 32'd9);
    bus.rsp_rdy = 1'b1;
    tick();

    // streaming: 4 ops with rsp_rdy and req_val held high
    begin
      int issued, got, last_cyc;
      logic xfer;
      issued = 0; got = 0; last_cyc = -1;
      ise_oval = 1'b1; ise_out = 32'h0000_00A5;
      drive_req(CUSTOM_1, 7'd0, 32'h0, 32'h0, 5'd10);
      for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
        if (bus.rsp_val) begin
          chk("stream_tag", 32'(bus.rsp_tag), 32'(10 + got));
          if (last_cyc >= 0) chk("stream_gap", 32'(cyc - last_cyc), 32'(OP_PERIOD));
          last_cyc = cyc;
          got++;
        end
        xfer = bus.req_val & bus.req_rdy;
        tick();
        if (xfer) begin
          issued++;
          if (issued == 4) bus.req_val = 1'b0;
          else bus.req_tag = bus.req_tag + 5'd1;
        end
      end
      chk("stream_count", 32'(got), 32'd4);
      bus.req_val = 1'b0;
      ise_oval = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
